vec_center_stream: RTL and testbench

Consumes one signed fixed-point vector plus its mean (the `vec_mean` result) and emits the mean-centered vector one element per handshake. It sits downstream of `vec_mean` in the normalization path and feeds the serial variance/scale stages.
- Input side: the vector is latched whole.
- Output side: elements are streamed serially under valid/ready backpressure.

---
 rtl/vec_center_stream_pkg.sv | 18 +
 rtl/fxp_sub_sat.sv | 29 ++
 rtl/vec_center_stream.sv | 72 +++++++
 tb/tb_vec_center_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_center_stream_pkg.sv
// Shared sizing, fixed-point limits and FSM encoding for the vector-centering path.
// Optional saturation in the subtractor is selected by VEC_CENTER_SAT_EN.
package vec_center_stream_pkg;

  localparam int ARR_WIDTH = 4;
  localparam int FXP_N     = 16;
  localparam int FXP_R     = 8;
  localparam int IDX_W     = $clog2(ARR_WIDTH);

  localparam logic signed [FXP_N-1:0] FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic signed [FXP_N-1:0] FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } center_state_t;

endpackage

// File: rtl/fxp_sub_sat.sv
// Combinational signed a-b; VEC_CENTER_SAT_EN clamps to the W-bit range, else wraps.
// Zero latency, no flow control of its own.
module fxp_sub_sat #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_diff
);

  logic signed [W:0] w_ext;

  assign w_ext = {i_a[W-1], i_a} - {i_b[W-1], i_b};

`ifdef VEC_CENTER_SAT_EN
  // The two top bits disagree only when the result left the W-bit range.
  always_comb begin
    o_diff = w_ext[W-1:0];
    if (w_ext[W] != w_ext[W-1]) begin
      o_diff = w_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  logic w_unused_msb;
  assign w_unused_msb = w_ext[W];
  assign o_diff       = w_ext[W-1:0];
`endif

endmodule

// File: rtl/vec_center_stream.sv
// Latches a vector and its mean, then streams (elem - mean) one element per handshake.
// First element one cycle after accept; holds outputs under out_ready low (VEC_CENTER_SAT_EN selects clamping).
module vec_center_stream
  import vec_center_stream_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ARR_WIDTH-1:0][FXP_N-1:0]   input_arr,
  input  logic signed [FXP_N-1:0]           mean_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [FXP_N-1:0]           out_data,
  output logic [IDX_W-1:0]                  out_idx,
  output logic                              out_last
);

  center_state_t                     r_state;
  logic [IDX_W-1:0]                  r_idx;
  logic [ARR_WIDTH-1:0][FXP_N-1:0]   r_vec;
  logic signed [FXP_N-1:0]           r_mean;

  logic                              w_last;
  logic signed [FXP_N-1:0]           w_elem;

  assign w_last = (r_state == STREAM) && (r_idx == IDX_W'(ARR_WIDTH-1));
  assign w_elem = r_vec[r_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_mean  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_vec   <= input_arr;
            r_mean  <= mean_in;
            r_idx   <= '0;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (w_last) begin
              r_state <= IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fxp_sub_sat #(.W(FXP_N)) u_sub (
    .i_a    (w_elem),
    .i_b    (r_mean),
    .o_diff (out_data)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == STREAM);
  assign out_idx   = r_idx;
  assign out_last  = w_last;

endmodule

// File: tb/tb_vec_center_stream.sv
// Directed bench for vec_center_stream: table of vectors plus hand-written corner sequences.
module tb_vec_center_stream;
  import vec_center_stream_pkg::*;

  logic                            clock = 1'b0;
  logic                            reset = 1'b1;
  logic                            in_valid = 1'b0;
  logic                            in_ready;
  logic [ARR_WIDTH-1:0][FXP_N-1:0] input_arr = '0;
  logic [FXP_N-1:0]                mean_in = '0;
  logic                            out_valid;
  logic                            out_ready = 1'b0;
  logic [FXP_N-1:0]                out_data;
  logic [IDX_W-1:0]                out_idx;
  logic                            out_last;

  vec_center_stream dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_arr (input_arr),
    .mean_in   (mean_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0][15:0] arr;
    logic [15:0]      mean;
    logic [3:0][15:0] exp;
  } vec_rec_t;

  vec_rec_t tbl[5];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_q[$];
  int last_q[$];

  always @(posedge clock) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready && out_last) last_q.push_back(cyc);
    end
    cyc++;
  end

  function automatic logic [3:0][15:0] mk(input logic [15:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_rec_t r, input int id);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk($sformatf("v%0d ready", id), in_ready, 1);
    input_arr = r.arr;
    mean_in   = r.mean;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk($sformatf("v%0d first valid", id), out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d e%0d data", id, k), out_data, r.exp[k]);
      chk($sformatf("v%0d e%0d idx", id, k), out_idx, k);
      chk($sformatf("v%0d e%0d last", id, k), out_last, (k == 3));
      @(negedge clock);
    end
    chk($sformatf("v%0d end valid", id), out_valid, 0);
    chk($sformatf("v%0d end ready", id), in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Q8.8 values
    tbl[0].arr  = mk(16'h0280, 16'hFC80, 16'h0480, 16'hFA80);
    tbl[0].mean = 16'hFF80;
    tbl[0].exp  = mk(16'h0300, 16'hFD00, 16'h0500, 16'hFB00);
    tbl[1].arr  = mk(16'h0A00, 16'h1400, 16'h1E00, 16'h2800);
    tbl[1].mean = 16'h1900;
    tbl[1].exp  = mk(16'hF100, 16'hFB00, 16'h0500, 16'h0F00);
    tbl[2].arr  = mk(16'h7FFF, 16'h0000, 16'h8000, 16'h0100);
    tbl[2].mean = 16'hFF00;
    tbl[3].arr  = mk(16'h8000, 16'h7FFF, 16'h0000, 16'hFF00);
    tbl[3].mean = 16'h0100;
`ifdef VEC_CENTER_SAT_EN
    tbl[2].exp  = mk(16'h7FFF, 16'h0100, 16'h8100, 16'h0200);
    tbl[3].exp  = mk(16'h8000, 16'h7EFF, 16'hFF00, 16'hFE00);
`else
    tbl[2].exp  = mk(16'h80FF, 16'h0100, 16'h8100, 16'h0200);
    tbl[3].exp  = mk(16'h7F00, 16'h7EFF, 16'hFF00, 16'hFE00);
`endif
    tbl[4].arr  = mk(16'h0040, 16'h0080, 16'h00C0, 16'h0100);
    tbl[4].mean = 16'h00A0;
    tbl[4].exp  = mk(16'hFFA0, 16'hFFE0, 16'h0020, 16'h0060);

    @(negedge clock);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_idx", out_idx, 0);
    chk("rst out_last", out_last, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Backpressure: stall three cycles on idx 1.
    input_arr = tbl[1].arr;
    mean_in   = tbl[1].mean;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp idx0 data", out_data, 16'hF100);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      chk($sformatf("bp hold%0d data", i), out_data, 16'hFB00);
      chk($sformatf("bp hold%0d idx", i), out_idx, 1);
      chk($sformatf("bp hold%0d valid", i), out_valid, 1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    chk("bp release data", out_data, 16'hFB00);
    chk("bp release idx", out_idx, 1);
    @(negedge clock);
    chk("bp idx2 data", out_data, 16'h0500);
    chk("bp idx2 idx", out_idx, 2);
    @(negedge clock);
    chk("bp idx3 data", out_data, 16'h0F00);
    chk("bp idx3 last", out_last, 1);
    @(negedge clock);
    chk("bp end valid", out_valid, 0);

    // Input isolation: new inputs and in_valid held during the stream.
    input_arr = tbl[0].arr;
    mean_in   = tbl[0].mean;
    in_valid  = 1'b1;
    @(negedge clock);
    input_arr = tbl[4].arr;
    mean_in   = tbl[4].mean;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("iso e%0d in_ready", k), in_ready, 0);
      chk($sformatf("iso e%0d data", k), out_data, tbl[0].exp[k]);
      @(negedge clock);
    end
    chk("iso gap in_ready", in_ready, 1);
    chk("iso gap out_valid", out_valid, 0);
    @(negedge clock);
    in_valid = 1'b0;
    chk("iso next valid", out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("iso next e%0d data", k), out_data, tbl[4].exp[k]);
      @(negedge clock);
    end

    // Asynchronous reset in the middle of a stream at idx 2.
    input_arr = tbl[1].arr;
    mean_in   = tbl[1].mean;
    in_valid  = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mrst pre idx", out_idx, 2);
    #2 reset = 1'b1;
    #1;
    chk("mrst out_valid", out_valid, 0);
    chk("mrst out_data", out_data, 0);
    chk("mrst out_idx", out_idx, 0);
    chk("mrst out_last", out_last, 0);
    chk("mrst in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    run_vec(tbl[4], 40);

    // Back-to-back: two vectors with in_valid held high.
    acc_q.delete();
    last_q.delete();
    input_arr = tbl[0].arr;
    mean_in   = tbl[0].mean;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    w = 0;
    while (last_q.size() < 2 && w < 40) begin
      @(negedge clock);
      if (acc_q.size() >= 2) in_valid = 1'b0;
      w++;
    end
    in_valid = 1'b0;
    chk("b2b completed", (last_q.size() >= 2 && acc_q.size() >= 2), 1);
    if (last_q.size() >= 2 && acc_q.size() >= 2) begin
      chk("b2b total cycles", last_q[1] - acc_q[0] + 1, 10);
      chk("b2b accept spacing", acc_q[1] - acc_q[0], ARR_WIDTH + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
